// File: rtl/multicycle_mem_responder.sv
// Word-addressed memory behind a fixed-latency request/ready handshake for a
// multi-cycle datapath: IDLE accepts, WAIT counts down, DONE pulses mem_ready.
module multicycle_mem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        mem_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, write_d;
  logic          err_q, err_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   din_q, din_d;
  logic [31:0]   dout_q, dout_d;
  logic          enter_done;
  logic          mem_we;

  logic [31:0]   mem_q [DEPTH];

  // Byte-address bits above the array wrap point are deliberately dropped.
  logic addr_unused;
  assign addr_unused = ^addr[31:AW+2];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    err_d      = err_q;
    idx_d      = idx_q;
    din_d      = din_q;
    enter_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          // Read+write together is accepted but flagged, like a misaligned access.
          write_d = mem_write;
          err_d   = (mem_read && mem_write) || (addr[1:0] != 2'b00);
          idx_d   = addr[AW+1:2];
          din_d   = din;
          if (LATENCY == 1) begin
            state_d    = DONE;
            cnt_d      = 4'd0;
            enter_done = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The _d view covers both the IDLE->DONE and WAIT->DONE entries; reset
    // on the commit edge abandons the write.
    mem_we = enter_done && write_d && !err_d && !reset;
    dout_d = dout_q;
    if (enter_done && !write_d && !err_d) dout_d = mem_q[idx_d];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      din_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
    end
  end

  // NOTE: the array has no reset branch; contents survive reset and the
  // storage can map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_d] <= din_d;
  end

  assign dout      = dout_q;
  assign mem_ready = (state_q == DONE);
  assign mem_busy  = (state_q != IDLE);
  assign mem_err   = mem_ready && err_q;

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Directed bench: a LATENCY=2 responder checked through a scoreboard queue,
// plus a LATENCY=1 responder for back-to-back held requests.
module tb_multicycle_mem_responder;

  typedef struct {
    logic        err;
    logic        chk_dout;
    logic [31:0] dout;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0, w0, r1, w1;
  logic [31:0] a0, d0, a1, d1;
  logic [31:0] dout0, dout1;
  logic        rdy0, busy0, err0, rdy1, busy1, err1;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] mem_m [1024];
  logic [31:0] dout_m;

  always #5 clk = ~clk;

  multicycle_mem_responder #(.LATENCY(2), .DEPTH(1024)) u_dut0 (
    .clk(clk), .reset(reset), .mem_read(r0), .mem_write(w0), .addr(a0),
    .din(d0), .dout(dout0), .mem_ready(rdy0), .mem_busy(busy0), .mem_err(err0)
  );

  multicycle_mem_responder #(.LATENCY(1), .DEPTH(1024)) u_dut1 (
    .clk(clk), .reset(reset), .mem_read(r1), .mem_write(w1), .addr(a1),
    .din(d1), .dout(dout1), .mem_ready(rdy1), .mem_busy(busy1), .mem_err(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on the LATENCY=2 responder; with noise, conflicting inputs
  // are driven while it is busy and must be ignored.
  task automatic access0(input string tag, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input bit noise);
    exp_t e;
    int   cycles;
    e.err      = (rd && wr) || (a[1:0] != 2'b00);
    e.chk_dout = 1'b1;
    if (!e.err && wr) mem_m[a[11:2]] = d;
    if (!e.err && rd && !wr) dout_m = mem_m[a[11:2]];
    e.dout = dout_m;
    sb0.push_back(e);

    @(negedge clk);
    r0 = rd; w0 = wr; a0 = a; d0 = d;
    @(negedge clk);
    cycles = 1;
    if (noise) begin
      r0 = 1'b0; w0 = 1'b1; a0 = a ^ 32'h4; d0 = ~d;
    end else begin
      r0 = 1'b0; w0 = 1'b0;
    end
    while (!rdy0 && cycles < 16) begin
      @(negedge clk);
      cycles++;
    end
    r0 = 1'b0; w0 = 1'b0;
    e = sb0.pop_front();
    check({tag, "_ready"}, 32'(rdy0), 32'd1);
    check({tag, "_latency"}, 32'(cycles), 32'd2);
    check({tag, "_busy"}, 32'(busy0), 32'd1);
    check({tag, "_err"}, 32'(err0), 32'(e.err));
    if (e.chk_dout) check({tag, "_dout"}, dout0, e.dout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    r0 = 0; w0 = 0; a0 = 0; d0 = 0;
    r1 = 0; w1 = 0; a1 = 0; d1 = 0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    dout_m = 32'h0;
    check("rst_dout", dout0, 32'h0);
    check("rst_ready", 32'(rdy0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);

    access0("wr_10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    access0("rd_10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    access0("rd_13_misal", 1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
    access0("wr_12_misal", 1'b0, 1'b1, 32'h12, 32'h1, 1'b0);
    access0("rd_10_again", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

    access0("wr_20", 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0);
    access0("rdwr_20", 1'b1, 1'b1, 32'h20, 32'h11111111, 1'b0);
    access0("rd_20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

    access0("wr_1000", 1'b0, 1'b1, 32'h1000, 32'hA5, 1'b0);
    access0("rd_0_wrap", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    access0("wr_ffc", 1'b0, 1'b1, 32'hFFC, 32'h0F0F0F0F, 1'b0);
    access0("rd_fffffffc", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);

    // Reset in WAIT abandons a write; reset also wins over a new request.
    access0("wr_40", 1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0);
    @(negedge clk);
    w0 = 1'b1; a0 = 32'h40; d0 = 32'h55;
    @(negedge clk);
    w0 = 1'b0;
    check("abort_wait_busy", 32'(busy0), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(rdy0), 32'd0);
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_dout", dout0, 32'h0);
    r0 = 1'b1; a0 = 32'h40;
    @(negedge clk);
    reset = 1'b0; r0 = 1'b0;
    dout_m = 32'h0;
    check("rst_prio_busy", 32'(busy0), 32'd0);
    check("rst_prio_ready", 32'(rdy0), 32'd0);
    access0("rd_40_kept", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);

    // LATENCY=1: seed word 0x8, then hold a read for four cycles.
    @(negedge clk);
    w1 = 1'b1; a1 = 32'h8; d1 = 32'h0BADF00D;
    @(negedge clk);
    w1 = 1'b0;
    check("l1_wr_ready", 32'(rdy1), 32'd1);
    check("l1_wr_err", 32'(err1), 32'd0);
    @(negedge clk);
    e.err = 1'b0; e.chk_dout = 1'b1; e.dout = 32'h0BADF00D;
    sb1.push_back(e);
    sb1.push_back(e);
    r1 = 1'b1; a1 = 32'h8;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("l1_busy_c%0d", i), 32'(busy1), 32'(i % 2));
      check($sformatf("l1_ready_c%0d", i), 32'(rdy1), 32'(i % 2));
      if (rdy1 && sb1.size() > 0) begin
        e = sb1.pop_front();
        check($sformatf("l1_dout_c%0d", i), dout1, e.dout);
        check($sformatf("l1_err_c%0d", i), 32'(err1), 32'(e.err));
      end
      if (i < 3) @(negedge clk);
    end
    r1 = 1'b0;
    check("l1_sb_empty", 32'(sb1.size()), 32'd0);
    @(negedge clk);
    check("l1_idle_busy", 32'(busy1), 32'd0);
    check("sb0_empty", 32'(sb0.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_mem_responder.md
MULTICYCLE_MEM_RESPONDER -- requirements
Module: multicycle_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2: cycles from request acceptance to mem_ready; legal range 1..15.
REQ-002 The block SHALL have parameter DEPTH, default 1024: number of 32-bit words; power of two.
REQ-003 The block SHALL have port clk  input  1  clock, rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port mem_read  input  1  read request from the multi-cycle control path.
REQ-006 The block SHALL have port mem_write  input  1  write request from the multi-cycle control path.
REQ-007 The block SHALL have port addr  input  32  byte address, already muxed by IorD upstream.
REQ-008 The block SHALL have port din  input  32  write data.
REQ-009 The block SHALL have port dout  output  32  read data, registered.
REQ-010 The block SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port mem_busy  output  1  high whenever the block is not in IDLE.
REQ-012 The block SHALL have port mem_err  output  1  error flag, valid only while mem_ready=1.

Function
REQ-013 The block SHALL implement states IDLE, WAIT and DONE, plus a 4-bit down-counter.
REQ-014 In IDLE, a rising edge with exactly one of mem_read or mem_write high SHALL latch op, addr and din, and enter WAIT with counter=LATENCY-1, or enter DONE directly if LATENCY=1.
REQ-015 In IDLE, a rising edge with mem_read=mem_write=1 SHALL be accepted as an error request: it follows the normal timing, performs no array access, and asserts mem_err with mem_ready.
REQ-016 In WAIT, the counter SHALL decrement each cycle, and the block SHALL enter DONE on the edge where the counter equals 1.
REQ-017 mem_ready SHALL be high only in DONE, for exactly one cycle, and SHALL occur exactly LATENCY cycles after the acceptance cycle.
REQ-018 DONE SHALL always return to IDLE; a request still asserted in the IDLE cycle that follows SHALL be accepted as a new access.
REQ-019 Inputs SHALL be ignored outside IDLE; latched values, not live inputs, SHALL govern the access.
REQ-020 The word index SHALL be addr[log2(DEPTH)+1:2]; upper bits SHALL be ignored, so addresses wrap modulo 4*DEPTH.
REQ-021 If addr[1:0]!=0, the access SHALL be misaligned: no array access, dout unchanged, mem_err=1 with mem_ready.
REQ-022 An aligned write SHALL commit to the array on the edge entering DONE; dout SHALL be unchanged.
REQ-023 An aligned read SHALL load dout on the edge entering DONE, and SHALL observe any write committed earlier.
REQ-024 dout SHALL hold its value between read completions.
REQ-025 mem_busy SHALL be 1 in WAIT and DONE and 0 in IDLE.

Reset
REQ-026 On reset, the state SHALL become IDLE, the counter 0, dout 0, mem_ready 0, mem_err 0 and mem_busy 0.
REQ-027 Array contents SHALL NOT be cleared by reset.
REQ-028 A reset asserted in WAIT SHALL abandon the pending access, with no write commit and no mem_ready pulse.
REQ-029 Reset SHALL take priority over any request sampled on the same edge.

Verification
REQ-030 LATENCY=2: write 0xDEADBEEF to addr 0x10 in cycle 0 -> mem_ready=1 in cycle 2, mem_err=0; read 0x10 -> dout=0xDEADBEEF with mem_ready two cycles after acceptance.
REQ-031 Read addr 0x13 -> mem_ready with mem_err=1 and dout unchanged; write din=0x1 to addr 0x12 -> mem_err=1 and a later read of 0x10 returns its prior value.
REQ-032 mem_read=mem_write=1 at addr 0x20 -> mem_err=1 at ready; word 0x20 is unmodified.
REQ-033 DEPTH=1024: write 0xA5 to addr 0x1000 -> a read of addr 0x0 returns 0xA5 (wrap).
REQ-034 Start a write of 0x55 to 0x40, then assert reset in the WAIT cycle -> no mem_ready, mem_busy=0 and dout=0 after reset; a read of 0x40 returns its old value.
REQ-035 LATENCY=1 with mem_read held high across four cycles at addr 0x8 -> mem_ready in cycles 1 and 3, and mem_busy pattern 0,1,0,1.
